// File: rtl/gat_ctrl_pkg.sv
// Shared types and constants for the GAT layer controller.
package gat_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOAD,
    LAUNCH,
    BUSY,
    DONE
  } state_e;

  // Bit positions of the BRAM load-done channels.
  localparam int CH_H_DATA    = 0;
  localparam int CH_NODE_INFO = 1;
  localparam int CH_WGT       = 2;

  // Layer 0 needs every buffer; later layers only need fresh weights.
  localparam logic [2:0] DEF_MASK_L0 = 3'((1 << CH_H_DATA) | (1 << CH_NODE_INFO) | (1 << CH_WGT));
  localparam logic [2:0] DEF_MASK_LN = 3'(1 << CH_WGT);

endpackage : gat_ctrl_pkg

// File: rtl/gat_layer_ctrl_if.sv
// Core handshake plus feature BRAM port-B, seen from controller (master) and core side (slave).
interface gat_layer_ctrl_if #(
  parameter int LAYER_W    = 1,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 16
);
  logic                  core_start_o;
  logic [LAYER_W-1:0]    core_layer_o;
  logic                  core_done_i;
  logic [ADDR_W-1:0]     feat_bram_addrb;
  logic [DATA_WIDTH-1:0] feat_bram_dout;

  modport master (
    output core_start_o, core_layer_o, feat_bram_addrb,
    input  core_done_i, feat_bram_dout
  );

  modport slave (
    input  core_start_o, core_layer_o, feat_bram_addrb,
    output core_done_i, feat_bram_dout
  );
endinterface : gat_layer_ctrl_if

// File: rtl/gat_rd_delay_line.sv
// Valid shift register of depth DEPTH for the feature readback path. The BRAM
// itself provides the data latency, so data is captured only into the final
// stage, on the cycle its valid bit enters that stage.
module gat_rd_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: shift valid along, capture data as valid enters the last stage.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    data_d = data_q;
    vld_d  = (vld_q << 1) | DEPTH'(in_valid);
    if (vld_d[DEPTH-1]) data_d = in_data;
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, so rd_data_o reads 0 out of reset.
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment only.
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q;
endmodule : gat_rd_delay_line

// File: rtl/gat_layer_ctrl.sv
// Control front end: sticky load tracking, multi-layer start/done sequencing
// with the GAT core, BUSY cycle counter and latency-aligned feature readback.
module gat_layer_ctrl
  import gat_ctrl_pkg::*;
#(
  parameter int                     NUM_LAYERS         = 2,
  parameter int                     NUM_LOAD_CH        = 3,
  parameter logic [NUM_LOAD_CH-1:0] REQ_MASK_L0        = DEF_MASK_L0,
  parameter logic [NUM_LOAD_CH-1:0] REQ_MASK_LN        = DEF_MASK_LN,
  parameter int                     FEAT_RD_LAT        = 2,
  parameter int                     DATA_WIDTH         = 8,
  parameter int                     NEW_FEATURE_ADDR_W = 16,
  parameter int                     CYC_W              = 32,
  parameter int                     LAYER_W            = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [LAYER_W-1:0]            start_layer_i,
  input  logic                          auto_chain_i,
  input  logic [NUM_LOAD_CH-1:0]        load_done_i,
  output logic                          gat_ready,
  output logic                          done_o,
  output logic [LAYER_W-1:0]            busy_layer_o,
  output logic [NUM_LOAD_CH-1:0]        load_status_o,
  output logic [CYC_W-1:0]              cycles_o,
  input  logic                          rd_req_i,
  input  logic [NEW_FEATURE_ADDR_W-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          rd_valid_o,
  output logic                          rd_err_o,
  gat_layer_ctrl_if.master              core_if
);
  state_e                          state_q, state_d;
  logic [LAYER_W-1:0]              layer_q, layer_d;
  logic [LAYER_W-1:0]              core_layer_q, core_layer_d;
  logic                            chain_q, chain_d;
  logic                            first_q, first_d;
  logic [CYC_W-1:0]                cycles_q, cycles_d;
  logic [NUM_LOAD_CH-1:0]          load_status_q, load_status_d;
  logic [NEW_FEATURE_ADDR_W-1:0]   addr_q, addr_d;
  logic                            rd_pend_q, rd_pend_d;
  logic                            err_q, err_d;
  logic [NUM_LOAD_CH-1:0]          cur_mask, start_mask, load_clr;
  logic                            rd_acc;

  // Sequencing FSM, load bookkeeping, cycle counter and read acceptance.
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    chain_d      = chain_q;
    first_d      = first_q;
    cycles_d     = cycles_q;
    load_clr     = '0;
    err_d        = 1'b0;
    cur_mask     = (layer_q == '0) ? REQ_MASK_L0 : REQ_MASK_LN;
    start_mask   = (start_layer_i == '0) ? REQ_MASK_L0 : REQ_MASK_LN;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (int'(start_layer_i) >= NUM_LAYERS) begin
            err_d = 1'b1;
          end else begin
            layer_d = start_layer_i;
            chain_d = auto_chain_i;
            first_d = 1'b1;
            state_d = ((load_status_q & start_mask) == start_mask) ? LAUNCH : WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        // A load pulse arriving this very cycle already counts.
        if (((load_status_q | load_done_i) & cur_mask) == cur_mask) state_d = LAUNCH;
      end
      LAUNCH: begin
        load_clr = cur_mask;
        // A chained run keeps accumulating after its first layer.
        if (!chain_q || first_q) cycles_d = '0;
        first_d  = 1'b0;
        state_d  = BUSY;
      end
      BUSY: begin
        if (cycles_q != '1) cycles_d = cycles_q + CYC_W'(1);
        if (core_if.core_done_i) begin
          if (chain_q && (int'(layer_q) < NUM_LAYERS - 1)) begin
            layer_d = layer_q + LAYER_W'(1);
            state_d = WAIT_LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Set wins over the launch-time clear.
    load_status_d = (load_status_q & ~load_clr) | load_done_i;

    // Core layer index changes only on entry to LAUNCH, so it is valid with core_start_o.
    core_layer_d = (state_d == LAUNCH) ? layer_d : core_layer_q;

    rd_acc    = rd_req_i && (state_q == IDLE);
    rd_pend_d = rd_acc;
    addr_d    = rd_acc ? rd_addr_i : addr_q;
    if (rd_req_i && (state_q != IDLE)) err_d = 1'b1;
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      layer_q       <= '0;
      core_layer_q  <= '0;
      chain_q       <= 1'b0;
      first_q       <= 1'b0;
      cycles_q      <= '0;
      load_status_q <= '0;
      addr_q        <= '0;
      rd_pend_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      core_layer_q  <= core_layer_d;
      chain_q       <= chain_d;
      first_q       <= first_d;
      cycles_q      <= cycles_d;
      load_status_q <= load_status_d;
      addr_q        <= addr_d;
      rd_pend_q     <= rd_pend_d;
      err_q         <= err_d;
    end
  end

  gat_rd_delay_line #(
    .DEPTH (FEAT_RD_LAT),
    .WIDTH (DATA_WIDTH)
  ) u_rd_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_pend_q),
    .in_data   (core_if.feat_bram_dout),
    .out_valid (rd_valid_o),
    .out_data  (rd_data_o)
  );

  assign gat_ready               = (state_q == IDLE);
  assign done_o                  = (state_q == DONE);
  assign busy_layer_o            = layer_q;
  assign load_status_o           = load_status_q;
  assign cycles_o                = cycles_q;
  assign rd_err_o                = err_q;
  assign core_if.core_start_o    = (state_q == LAUNCH);
  assign core_if.core_layer_o    = core_layer_q;
  assign core_if.feat_bram_addrb = addr_q;
endmodule : gat_layer_ctrl

// File: tb/tb_gat_layer_ctrl.sv
// Self-checking bench for gat_layer_ctrl: table-driven single-layer launches,
// hand-written multi-cycle sequences, and randomized runs against a model.
module tb_gat_layer_ctrl;
  localparam int NL  = 2;
  localparam int NCH = 3;
  localparam int LAT = 2;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int CW  = 32;
  localparam int LW  = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_i = 1'b0;
  logic [LW-1:0]  start_layer_i = '0;
  logic           auto_chain_i = 1'b0;
  logic [NCH-1:0] load_done_i = '0;
  logic           gat_ready, done_o, rd_valid_o, rd_err_o;
  logic [LW-1:0]  busy_layer_o;
  logic [NCH-1:0] load_status_o;
  logic [CW-1:0]  cycles_o;
  logic           rd_req_i = 1'b0;
  logic [AW-1:0]  rd_addr_i = '0;
  logic [DW-1:0]  rd_data_o;

  gat_layer_ctrl_if #(.LAYER_W(LW), .DATA_WIDTH(DW), .ADDR_W(AW)) core_if ();

  gat_layer_ctrl #(
    .NUM_LAYERS(NL), .NUM_LOAD_CH(NCH), .REQ_MASK_L0(3'b111), .REQ_MASK_LN(3'b100),
    .FEAT_RD_LAT(LAT), .DATA_WIDTH(DW), .NEW_FEATURE_ADDR_W(AW), .CYC_W(CW), .LAYER_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_layer_i(start_layer_i),
    .auto_chain_i(auto_chain_i), .load_done_i(load_done_i), .gat_ready(gat_ready),
    .done_o(done_o), .busy_layer_o(busy_layer_o), .load_status_o(load_status_o),
    .cycles_o(cycles_o), .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .rd_err_o(rd_err_o), .core_if(core_if)
  );

  always #5 clk = ~clk;

  // Feature BRAM model: one-cycle registered read.
  function automatic logic [DW-1:0] bram_val(input logic [AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd37 + 32'd90;
    return t[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk) core_if.feat_bram_dout <= bram_val(core_if.feat_bram_addrb);

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  int n_cmp = 0, n_err = 0, cyc = 0, n_start = 0, n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, sample after the edge, and run the per-cycle readback scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      check("rd_valid", rd_valid_o, 1);
      check("rd_data", rd_data_o, rd_q[0].data);
      void'(rd_q.pop_front());
    end else begin
      check("rd_valid_idle", rd_valid_o, 0);
    end
    if (core_if.core_start_o) n_start++;
    if (done_o) n_done++;
  endtask

  task automatic rd_issue(input logic [AW-1:0] a, input bit accept);
    rd_req_i  = 1'b1;
    rd_addr_i = a;
    if (accept) rd_q.push_back('{due: cyc + 1 + LAT, data: bram_val(a)});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, gat_ready, 1);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_busy_layer"}, busy_layer_o, 0);
    check({tag, "_status"}, load_status_o, 0);
    check({tag, "_cycles"}, cycles_o, 0);
    check({tag, "_core_start"}, core_if.core_start_o, 0);
    check({tag, "_core_layer"}, core_if.core_layer_o, 0);
    check({tag, "_rd_valid"}, rd_valid_o, 0);
    check({tag, "_rd_data"}, rd_data_o, 0);
    check({tag, "_rd_err"}, rd_err_o, 0);
    check({tag, "_addrb"}, core_if.feat_bram_addrb, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start_i = 1'b0; load_done_i = '0; rd_req_i = 1'b0; auto_chain_i = 1'b0;
    start_layer_i = '0; core_if.core_done_i = 1'b0;
    rd_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_load(input logic [NCH-1:0] m);
    load_done_i = m;
    tick();
    load_done_i = '0;
  endtask

  task automatic start_run(input int layer, input bit chain);
    start_layer_i = LW'(layer);
    auto_chain_i  = chain;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
  endtask

  // Called in a cycle where the core is running or launched; core_done after lat more cycles.
  task automatic core_run(input int lat);
    repeat (lat) tick();
    core_if.core_done_i = 1'b1;
    tick();
    core_if.core_done_i = 1'b0;
  endtask

  function automatic logic [NCH-1:0] need(input int l);
    return (l == 0) ? 3'b111 : 3'b100;
  endfunction

  function automatic logic [NCH-1:0] rand_pulse();
    logic [NCH-1:0] r;
    r = NCH'($urandom);
    return ($urandom_range(0, 2) == 0) ? r : '0;
  endfunction

  typedef struct {
    logic [NCH-1:0] preload;
    int             layer;
    logic [NCH-1:0] late;
    int             lat;
    int             exp_off;
    logic [NCH-1:0] exp_status;
  } vec_t;

  vec_t           vecs[6];
  logic [NCH-1:0] status_m, p;
  int             total, lat, guard, last, n_done0, n_start0;
  bit             pending;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    vecs[0] = '{3'b111, 0, 3'b000, 3, 1, 3'b000};
    vecs[1] = '{3'b100, 1, 3'b000, 2, 1, 3'b000};
    vecs[2] = '{3'b111, 1, 3'b000, 1, 1, 3'b011};
    vecs[3] = '{3'b011, 1, 3'b100, 4, 2, 3'b011};
    vecs[4] = '{3'b001, 0, 3'b110, 2, 2, 3'b000};
    vecs[5] = '{3'b110, 0, 3'b001, 5, 2, 3'b000};

    // Reset values while held in reset.
    #2;
    check_reset_vals("rst");
    do_reset();

    // Table-driven single-layer launches.
    foreach (vecs[i]) begin
      do_reset();
      if (vecs[i].preload != '0) pulse_load(vecs[i].preload);
      tick();
      start_run(vecs[i].layer, 1'b0);
      check("t_ready_low", gat_ready, 0);
      check("t_start_t1", core_if.core_start_o, (vecs[i].exp_off == 1));
      if (vecs[i].exp_off != 1) begin
        pulse_load(vecs[i].late);
        check("t_start_late", core_if.core_start_o, 1);
      end
      check("t_core_layer", core_if.core_layer_o, vecs[i].layer);
      check("t_busy_layer", busy_layer_o, vecs[i].layer);
      core_run(vecs[i].lat);
      check("t_done", done_o, 1);
      check("t_cycles", cycles_o, vecs[i].lat);
      tick();
      check("t_done_once", done_o, 0);
      check("t_ready", gat_ready, 1);
      check("t_status", load_status_o, vecs[i].exp_status);
    end

    // core_done in IDLE is ignored.
    do_reset();
    core_if.core_done_i = 1'b1;
    tick();
    core_if.core_done_i = 1'b0;
    tick();
    check("idle_done_ignored", done_o, 0);
    check("idle_still_ready", gat_ready, 1);

    // Start before any load: wait for bits 0, 1, 2 one at a time.
    do_reset();
    start_run(0, 1'b0);
    check("w_no_start", core_if.core_start_o, 0);
    pulse_load(3'b001);
    check("w_no_start_b0", core_if.core_start_o, 0);
    pulse_load(3'b010);
    check("w_no_start_b1", core_if.core_start_o, 0);
    pulse_load(3'b100);
    check("w_start_after_b2", core_if.core_start_o, 1);
    check("w_status_full", load_status_o, 3'b111);
    // core_done during LAUNCH is ignored; the run stays busy.
    core_if.core_done_i = 1'b1;
    tick();
    core_if.core_done_i = 1'b0;
    check("w_launch_done_ignored", done_o, 0);
    check("w_single_pulse", core_if.core_start_o, 0);
    core_run(2);
    check("w_done", done_o, 1);
    tick();

    // Chained two-layer run with a weight reload between layers.
    do_reset();
    pulse_load(3'b111);
    n_done0 = n_done;
    start_run(0, 1'b1);
    check("c_start0", core_if.core_start_o, 1);
    check("c_layer0", core_if.core_layer_o, 0);
    core_run(4);
    check("c_no_done_mid", done_o, 0);
    check("c_busy_layer1", busy_layer_o, 1);
    check("c_not_ready", gat_ready, 0);
    for (int k = 0; k < 3; k++) begin
      check("c_wait_wgt", core_if.core_start_o, 0);
      tick();
    end
    pulse_load(3'b100);
    check("c_start1", core_if.core_start_o, 1);
    check("c_layer1", core_if.core_layer_o, 1);
    core_run(3);
    check("c_done", done_o, 1);
    check("c_cycles_total", cycles_o, 7);
    tick();
    check("c_ready", gat_ready, 1);
    check("c_one_done", n_done - n_done0, 1);

    // Readback in IDLE: 5, 6, 7 back to back.
    do_reset();
    for (int a = 5; a <= 7; a++) begin
      rd_issue(AW'(a), 1'b1);
      tick();
      check("rb_addrb", core_if.feat_bram_addrb, a);
    end
    rd_req_i = 1'b0;
    repeat (5) tick();
    // Pipe entries complete even when a start follows immediately.
    pulse_load(3'b111);
    rd_issue(16'd20, 1'b1);
    tick();
    rd_issue(16'h1234, 1'b1);
    start_layer_i = '0; auto_chain_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0; rd_req_i = 1'b0;
    check("rb_start_launch", core_if.core_start_o, 1);
    tick();
    // Request while BUSY is rejected.
    rd_issue(16'd9, 1'b0);
    tick();
    rd_req_i = 1'b0;
    check("rb_err_pulse", rd_err_o, 1);
    tick();
    check("rb_err_clear", rd_err_o, 0);
    core_run(1);
    tick();
    repeat (4) tick();
    check("rb_drained", rd_q.size(), 0);

    // Load-done on wgt in the LAUNCH cycle survives the clear.
    do_reset();
    pulse_load(3'b111);
    start_run(0, 1'b0);
    check("s_launch", core_if.core_start_o, 1);
    pulse_load(3'b100);
    check("s_set_wins", load_status_o, 3'b100);
    core_run(1);
    check("s_done", done_o, 1);
    tick();

    // Reset asserted mid-BUSY.
    do_reset();
    pulse_load(3'b111);
    start_run(0, 1'b0);
    tick();
    tick();
    check("r_in_busy", gat_ready, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    n_done0 = n_done;
    n_start0 = n_start;
    tick();
    rst_n = 1'b1;
    core_if.core_done_i = 1'b1;
    tick();
    core_if.core_done_i = 1'b0;
    repeat (3) tick();
    check("r_no_done", n_done - n_done0, 0);
    check("r_no_start", n_start - n_start0, 0);
    check("r_ready", gat_ready, 1);

    // Randomized readback bursts in IDLE.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) rd_issue(AW'($urandom), 1'b1);
      else rd_req_i = 1'b0;
      tick();
    end
    rd_req_i = 1'b0;
    repeat (5) tick();

    // Randomized runs against a sticky-bit model.
    do_reset();
    status_m = '0;
    for (int run = 0; run < 20; run++) begin
      int l0;
      bit ch;
      l0    = $urandom_range(0, NL - 1);
      ch    = 1'($urandom_range(0, 1));
      total = 0;
      repeat ($urandom_range(0, 3)) begin
        p = rand_pulse();
        status_m |= p;
        pulse_load(p);
      end
      pending = ((status_m & need(l0)) == need(l0));
      start_run(l0, ch);
      last = ch ? NL - 1 : l0;
      for (int L = l0; L <= last; L++) begin
        guard = 0;
        while (!pending) begin
          check("m_no_start", core_if.core_start_o, 0);
          p = (guard > 20) ? need(L) : rand_pulse();
          status_m |= p;
          pending = ((status_m & need(L)) == need(L));
          pulse_load(p);
          guard++;
        end
        check("m_start", core_if.core_start_o, 1);
        check("m_layer", core_if.core_layer_o, L);
        p = rand_pulse();
        status_m = (status_m & ~need(L)) | p;
        lat = $urandom_range(1, 5);
        total += lat;
        pulse_load(p);
        for (int k = 1; k < lat; k++) begin
          check("m_busy_no_start", core_if.core_start_o, 0);
          p = rand_pulse();
          status_m |= p;
          pulse_load(p);
        end
        p = rand_pulse();
        status_m |= p;
        load_done_i = p;
        core_if.core_done_i = 1'b1;
        tick();
        core_if.core_done_i = 1'b0;
        load_done_i = '0;
        pending = 1'b0;
      end
      check("m_done", done_o, 1);
      check("m_cycles", cycles_o, total);
      tick();
      check("m_done_once", done_o, 0);
      check("m_ready", gat_ready, 1);
      check("m_status", load_status_o, status_m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule : tb_gat_layer_ctrl
